// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory request/grant/response, redirect from
// execute, and the valid/ready instruction hand-off to decode.
interface instr_fetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instr;
   logic [6:0]      opcode;
   logic [XLEN-1:0] pc;
   logic            misalign_err;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redirect, redirect_pc,
      output instr_valid,
      input  instr_ready,
      output instr, opcode, pc, misalign_err
   );

   // Environment side: memory, execute and decode
   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redirect, redirect_pc,
      input  instr_valid,
      output instr_ready,
      input  instr, opcode, pc, misalign_err
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: one outstanding word read at a time, result held in a
// valid/ready register for decode. Redirects from execute take priority; a
// misaligned redirect target halts fetch until reset.
module instr_fetch_unit #(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic              clk,
   input logic              reset,
   instr_fetch_unit_if.master bus
);

   localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

   typedef enum logic [2:0] {StReq, StWait, StHold, StDrain, StHalt} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            misalign_q, misalign_d;
   logic            redirect_misaligned;

   assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StReq;
         fetch_pc_q <= RESET_PC;
         instr_q    <= Nop;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   // Next-state logic; a redirect overrides grant, response and consume
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;

      if (state_q != StHalt && bus.redirect) begin
         // Held instruction is dropped as if consumed
         valid_d = 1'b0;
         if (redirect_misaligned) begin
            misalign_d = 1'b1;
            state_d    = StHalt;
         end else begin
            fetch_pc_d = bus.redirect_pc;
            case (state_q)
               StReq:           state_d = bus.imem_gnt ? StDrain : StReq;
               // Response landing this cycle is discarded and retires the request
               StWait, StDrain: state_d = bus.imem_rvalid ? StReq : StDrain;
               StHold:          state_d = StReq;
               default:         state_d = state_q;
            endcase
         end
      end else begin
         unique case (state_q)
            StReq: begin
               if (bus.imem_gnt) state_d = StWait;
            end
            StWait: begin
               if (bus.imem_rvalid) begin
                  instr_d = bus.imem_rdata;
                  pc_d    = fetch_pc_q;
                  valid_d = 1'b1;
                  state_d = StHold;
               end
            end
            StHold: begin
               if (bus.instr_ready) begin
                  valid_d    = 1'b0;
                  fetch_pc_d = fetch_pc_q + XLEN'(4);
                  state_d    = StReq;
               end
            end
            StDrain: begin
               if (bus.imem_rvalid) state_d = StReq;
            end
            StHalt: begin
               state_d = StHalt;
            end
            default: begin
               state_d = StReq;
            end
         endcase
      end
   end

   // Outputs are registered state except the request, which drops during reset
   always_comb begin
      bus.imem_req     = (state_q == StReq) && !reset;
      bus.imem_addr    = fetch_pc_q & ~XLEN'(3);
      bus.instr_valid  = valid_q;
      bus.instr        = instr_q;
      bus.opcode       = instr_q[6:0];
      bus.pc           = pc_q;
      bus.misalign_err = misalign_q;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a table of directed cycles, hand-written redirect,
// misalign and wrap sequences, then randomized traffic against a transaction-level
// model of the fetch contract.
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset2 = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.XLEN(32)) bus ();
   instr_fetch_unit_if #(.XLEN(32)) bus2 ();

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2.master)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later
   task automatic apply(input logic rst, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic rdr, input logic [31:0] rpc,
                        input logic rdy);
      @(negedge clk);
      reset           = rst;
      bus.imem_gnt    = gnt;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rd;
      bus.redirect    = rdr;
      bus.redirect_pc = rpc;
      bus.instr_ready = rdy;
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        rdr;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[13];

   // Reference model: facts about the fetch contract, not FSM states
   logic        m_out;      // a granted request has no response yet
   logic        m_discard;  // that response belongs to a redirected-away path
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [31:0] m_next;
   logic        m_halt;
   logic        m_err;
   logic        m_req;
   logic        env_pend;
   int          env_delay;
   int          halt_cnt;
   logic        req_seen;

   task automatic model_reset();
      m_out = 1'b0; m_discard = 1'b0; m_valid = 1'b0; m_instr = 32'h13;
      m_pc = 32'h0; m_next = 32'h0; m_halt = 1'b0; m_err = 1'b0;
   endtask

   initial begin
      bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
      bus.redirect = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
      bus2.imem_gnt = 0; bus2.imem_rvalid = 0; bus2.imem_rdata = 0;
      bus2.redirect = 0; bus2.redirect_pc = 0; bus2.instr_ready = 0;
      repeat (2) @(posedge clk);

      // rst gnt rv rdata rdr rpc rdy | req addr valid pc instr
      vecs[0]  = '{1, 0, 0, 32'h0, 0, 32'h0, 0,        0, 32'h0, 0, 32'h0, 32'h13};
      vecs[1]  = '{0, 1, 0, 32'h0, 0, 32'h0, 0,        1, 32'h0, 0, 32'h0, 32'h13};
      vecs[2]  = '{0, 0, 1, 32'h33, 0, 32'h0, 0,       0, 32'h0, 0, 32'h0, 32'h13};
      vecs[3]  = '{0, 0, 0, 32'h0, 0, 32'h0, 1,        0, 32'h0, 1, 32'h0, 32'h33};
      vecs[4]  = '{0, 1, 0, 32'h0, 0, 32'h0, 0,        1, 32'h4, 0, 32'h0, 32'h33};
      vecs[5]  = '{0, 0, 1, 32'h0050_0093, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h33};
      for (int i = 6; i <= 10; i++)
         vecs[i] = '{0, 0, 0, 32'h0, 0, 32'h0, 0,      0, 32'h0, 1, 32'h4, 32'h0050_0093};
      vecs[11] = '{0, 0, 0, 32'h0, 0, 32'h0, 1,        0, 32'h0, 1, 32'h4, 32'h0050_0093};
      vecs[12] = '{0, 0, 0, 32'h0, 0, 32'h0, 0,        1, 32'h8, 0, 32'h4, 32'h0050_0093};

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdr,
               vecs[i].rpc, vecs[i].rdy);
         chk($sformatf("vec%0d req", i), 32'(bus.imem_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), bus.imem_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d pc", i), bus.pc, vecs[i].e_pc);
         chk($sformatf("vec%0d instr", i), bus.instr, vecs[i].e_instr);
         chk($sformatf("vec%0d opcode", i), 32'(bus.opcode), 32'(vecs[i].e_instr[6:0]));
         chk($sformatf("vec%0d err", i), 32'(bus.misalign_err), 32'h0);
      end

      // Redirect while waiting: late response must be drained and dropped
      apply(0, 1, 0, 32'h0, 0, 32'h0, 0);
      chk("rdw grant addr", bus.imem_addr, 32'h8);
      apply(0, 0, 0, 32'h0, 1, 32'h100, 0);
      chk("rdw redirect req", 32'(bus.imem_req), 32'h0);
      apply(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("rdw drain req", 32'(bus.imem_req), 32'h0);
      apply(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
      chk("rdw drain valid", 32'(bus.instr_valid), 32'h0);
      apply(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("rdw new req", 32'(bus.imem_req), 32'h1);
      chk("rdw new addr", bus.imem_addr, 32'h100);
      chk("rdw valid", 32'(bus.instr_valid), 32'h0);
      chk("rdw instr kept", bus.instr, 32'h0050_0093);
      apply(0, 1, 0, 32'h0, 0, 32'h0, 0);
      apply(0, 0, 1, 32'h0000_0013, 0, 32'h0, 0);
      // Redirect in HOLD together with ready: target wins over pc+4
      apply(0, 0, 0, 32'h0, 1, 32'h40, 1);
      chk("rdh valid", 32'(bus.instr_valid), 32'h1);
      chk("rdh pc", bus.pc, 32'h100);
      apply(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("rdh valid after", 32'(bus.instr_valid), 32'h0);
      chk("rdh req", 32'(bus.imem_req), 32'h1);
      chk("rdh addr", bus.imem_addr, 32'h40);

      // Misaligned redirect halts fetch until reset
      apply(0, 0, 0, 32'h0, 1, 32'h102, 0);
      for (int i = 0; i < 20; i++) begin
         apply(0, 1'($urandom), 1'($urandom), $urandom, 0, 32'h0, 1);
         chk($sformatf("halt%0d req", i), 32'(bus.imem_req), 32'h0);
         chk($sformatf("halt%0d valid", i), 32'(bus.instr_valid), 32'h0);
         chk($sformatf("halt%0d err", i), 32'(bus.misalign_err), 32'h1);
      end
      apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("halt reset req", 32'(bus.imem_req), 32'h0);
      apply(0, 0, 0, 32'h0, 0, 32'h0, 0);
      chk("halt cleared err", 32'(bus.misalign_err), 32'h0);
      chk("halt restart req", 32'(bus.imem_req), 32'h1);
      chk("halt restart addr", bus.imem_addr, 32'h0);
      chk("halt restart instr", bus.instr, 32'h13);

      // Wrap instance: grant delayed 3 cycles at the top of the address space
      @(negedge clk);
      reset2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("wrap hold%0d req", i), 32'(bus2.imem_req), 32'h1);
         chk($sformatf("wrap hold%0d addr", i), bus2.imem_addr, 32'hFFFF_FFFC);
         @(negedge clk);
      end
      bus2.imem_gnt = 1'b1;
      #1;
      chk("wrap gnt addr", bus2.imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      bus2.imem_gnt = 1'b0;
      bus2.imem_rvalid = 1'b1;
      bus2.imem_rdata = 32'h0000_0013;
      @(negedge clk);
      bus2.imem_rvalid = 1'b0;
      bus2.instr_ready = 1'b1;
      #1;
      chk("wrap valid", 32'(bus2.instr_valid), 32'h1);
      chk("wrap pc", bus2.pc, 32'hFFFF_FFFC);
      @(negedge clk);
      bus2.instr_ready = 1'b0;
      #1;
      chk("wrap next req", 32'(bus2.imem_req), 32'h1);
      chk("wrap next addr", bus2.imem_addr, 32'h0);

      // Randomized traffic against the model
      apply(1, 0, 0, 32'h0, 0, 32'h0, 0);
      model_reset();
      env_pend = 1'b0;
      env_delay = 0;
      halt_cnt = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         reset = (halt_cnt > 8) || ($urandom_range(0, 299) == 0);
         bus.imem_gnt = ($urandom_range(0, 2) != 0);
         bus.imem_rdata = $urandom;
         if (env_pend && env_delay == 0) bus.imem_rvalid = 1'b1;
         else bus.imem_rvalid = !env_pend && ($urandom_range(0, 9) == 0);
         bus.redirect = ($urandom_range(0, 14) == 0);
         case ($urandom_range(0, 9))
            0:       bus.redirect_pc = $urandom | 32'h1;
            1:       bus.redirect_pc = 32'hFFFF_FFF8;
            default: bus.redirect_pc = 32'($urandom_range(0, 255)) << 2;
         endcase
         bus.instr_ready = ($urandom_range(0, 2) != 0);
         #1;
         m_req = !reset && !m_halt && !m_out && !m_valid;
         req_seen = bus.imem_req;
         chk("rnd req", 32'(bus.imem_req), 32'(m_req));
         if (m_req) chk("rnd addr", bus.imem_addr, m_next);
         chk("rnd valid", 32'(bus.instr_valid), 32'(m_valid));
         chk("rnd instr", bus.instr, m_instr);
         chk("rnd opcode", 32'(bus.opcode), 32'(m_instr[6:0]));
         chk("rnd pc", bus.pc, m_pc);
         chk("rnd err", 32'(bus.misalign_err), 32'(m_err));
         @(posedge clk);
         // Memory environment
         if (bus.imem_rvalid && env_pend) env_pend = 1'b0;
         else if (env_pend && env_delay > 0) env_delay--;
         if (req_seen && bus.imem_gnt) begin
            env_pend = 1'b1;
            env_delay = $urandom_range(0, 3);
         end
         // Model update
         if (reset) begin
            model_reset();
            halt_cnt = 0;
         end else if (m_halt) begin
            halt_cnt++;
         end else if (bus.redirect) begin
            m_valid = 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
               m_halt = 1'b1;
               m_err = 1'b1;
            end else begin
               m_next = bus.redirect_pc;
               if (m_req && bus.imem_gnt) begin
                  m_out = 1'b1;
                  m_discard = 1'b1;
               end else if (m_out) begin
                  if (bus.imem_rvalid) m_out = 1'b0;
                  else m_discard = 1'b1;
               end
            end
         end else if (m_req && bus.imem_gnt) begin
            m_out = 1'b1;
            m_discard = 1'b0;
         end else if (m_out && bus.imem_rvalid) begin
            m_out = 1'b0;
            if (!m_discard) begin
               m_valid = 1'b1;
               m_instr = bus.imem_rdata;
               m_pc = m_next;
            end
         end else if (m_valid && bus.instr_ready) begin
            m_valid = 1'b0;
            m_next = m_next + 32'd4;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
